uart_tx_serializer: RTL and testbench

//  Downstream consumer of the RV32IM core's 9-bit UART MMIO strobe {valid, byte}.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_byte_fifo.sv | 67 ++++++
 rtl/uart_tx_serializer.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path fed by the core's MMIO strobe.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int          FRAME_DATA_BITS = 8;
    localparam logic [31:0] UART_MMIO_ADDR  = 32'h0000_fff0;
    localparam int          UART_VALID_BIT  = 8;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO; a push on a full FIFO is accepted only alongside a pop.
module sync_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [FRAME_DATA_BITS-1:0]   push_data,
    input  logic                         pop,
    output logic [FRAME_DATA_BITS-1:0]   pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [FRAME_DATA_BITS-1:0] mem_q [DEPTH];
    logic [FRAME_DATA_BITS-1:0] mem_d [DEPTH];
    logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       pop_ok;
    logic                       push_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pop_ok   = pop && !empty;
        // Room freed by a same-cycle pop lets a full FIFO still take the byte.
        push_ok  = push && (!full || pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// Buffers MMIO UART bytes and shifts them out as 8N1 frames (8E1 with UART_TX_PARITY_EN).
//  state   | meaning
//  IDLE    | line high, waiting for a queued byte
//  START   | start bit (low)
//  DATA    | eight data bits, LSB first
//  PARITY  | even parity bit (UART_TX_PARITY_EN builds only)
//  STOP    | stop bit (high); chains straight into START if more bytes wait
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [8:0]                    uart_in,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam int                BIT_W     = $clog2(FRAME_DATA_BITS);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_DATA_BITS - 1);

    uart_state_e                state_q, state_d;
    logic [BAUD_W-1:0]          baud_q, baud_d;
    logic [BIT_W-1:0]           bit_idx_q, bit_idx_d;
    logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
    logic                       tx_q, tx_d;
    logic                       busy_q, busy_d;
    logic                       overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
    logic                       parity_q, parity_d;
`endif

    logic                       fifo_push;
    logic                       fifo_pop;
    logic [FRAME_DATA_BITS-1:0] fifo_data;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       baud_wrap;

    assign fifo_push = uart_in[UART_VALID_BIT];

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (uart_in[FRAME_DATA_BITS-1:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        fifo_pop  = 1'b0;
        baud_wrap = (baud_q == BAUD_LAST);

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_START;
                    baud_d   = '0;
                end
            end
            ST_START: begin
                baud_d = baud_q + BAUD_W'(1);
                if (baud_wrap) begin
                    state_d   = ST_DATA;
                    baud_d    = '0;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                baud_d = baud_q + BAUD_W'(1);
                if (baud_wrap) begin
                    baud_d    = '0;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + BIT_W'(1);
                    if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                baud_d = baud_q + BAUD_W'(1);
                if (baud_wrap) begin
                    state_d = ST_STOP;
                    baud_d  = '0;
                end
            end
`endif
            ST_STOP: begin
                baud_d = baud_q + BAUD_W'(1);
                if (baud_wrap) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_START;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
            end
        endcase

        if (fifo_pop) begin
            shift_d  = fifo_data;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_data;
`endif
        end

        // tx is driven from the next state so the line changes on the same edge as the FSM.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase

        busy_d     = !fifo_empty || (state_q != ST_IDLE);
        overflow_d = overflow_q || (fifo_push && fifo_full && !fifo_pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: frame-level queue model checked every cycle plus directed literal checks.
module tb_uart_tx_serializer;

    localparam int C     = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic       clock;
    logic       reset_n;
    logic [8:0] uart_in;
    logic       tx;
    logic       busy;
    logic       overflow;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_serializer #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .uart_in    (uart_in),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which line level bit-time idx of a frame carrying byte b must show.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Model: a queue of bytes and "frame started at edge start" bookkeeping.
    logic [7:0] m_q[$];
    bit         m_in_frame = 0;
    int         m_start    = 0;
    logic [7:0] m_cur      = 8'h00;
    bit         m_ovf      = 0;
    bit         m_tx       = 1;
    bit         m_busy     = 0;
    bit         m_busy_nxt = 0;
    int         cyc        = 0;

    always @(posedge clock) begin
        cyc++;
        if (!reset_n) begin
            m_q.delete();
            m_in_frame = 0;
            m_ovf      = 0;
            m_tx       = 1;
            m_busy     = 0;
            m_busy_nxt = 0;
        end else begin
            m_busy = m_busy_nxt;
            if (m_in_frame && (cyc - m_start == FL * C)) m_in_frame = 0;
            if (!m_in_frame && m_q.size() > 0) begin
                m_cur      = m_q.pop_front();
                m_start    = cyc;
                m_in_frame = 1;
            end
            if (uart_in[8]) begin
                if (m_q.size() < DEPTH) m_q.push_back(uart_in[7:0]);
                else m_ovf = 1;
            end
            m_tx       = m_in_frame ? frame_bit(m_cur, (cyc - m_start) / C) : 1'b1;
            m_busy_nxt = m_in_frame || (m_q.size() > 0);
            #1;
            if (reset_n) begin
                check("model_tx",       32'(tx),         32'(m_tx));
                check("model_busy",     32'(busy),       32'(m_busy));
                check("model_overflow", 32'(overflow),   32'(m_ovf));
                check("model_count",    32'(fifo_count), 32'(m_q.size()));
            end
        end
    end

    logic [7:0] bytes_buf [8];
    int         first_edge;

    task automatic push_burst(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (i == 0) first_edge = cyc + 1;
            uart_in = {1'b1, bytes_buf[i]};
        end
        @(negedge clock);
        uart_in = 9'h000;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 1000; k++) begin
            @(negedge clock);
            if (!busy && !m_in_frame && m_q.size() == 0 && !m_busy_nxt) break;
        end
        check({name, "_idle_timeout"}, 32'(k < 1000), 32'd1);
    endtask

    // Push one byte and record the line once per bit time, starting one edge after the push.
    task automatic send_and_sample(input logic [7:0] b, output logic [10:0] seq);
        seq = '0;
        bytes_buf[0] = b;
        push_burst(1);
        check("push_count", 32'(fifo_count), 32'd1);
        for (int i = 0; i < FL; i++) begin
            @(negedge clock);
            seq[i] = tx;
            if (i == 0) check("pop_count", 32'(fifo_count), 32'd0);
            repeat (C - 1) @(negedge clock);
        end
    endtask

    initial begin
        logic [10:0] seq;
        int          e_stop;

        reset_n = 1'b0;
        uart_in = 9'h000;
        repeat (3) @(negedge clock);
        check("rst_tx",       32'(tx),         32'd1);
        check("rst_busy",     32'(busy),       32'd0);
        check("rst_overflow", 32'(overflow),   32'd0);
        check("rst_count",    32'(fifo_count), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Single 0x41 frame.
        send_and_sample(8'h41, seq);
`ifdef UART_TX_PARITY_EN
        check("t1_frame_bits", 32'(seq), 32'h482);
`else
        check("t1_frame_bits", 32'(seq), 32'h282);
`endif
        @(negedge clock);
        check("t1_busy_hold", 32'(busy), 32'd1);
        @(negedge clock);
        check("t1_busy_drop", 32'(busy), 32'd0);
        check("t1_tx_idle",   32'(tx),   32'd1);
        wait_idle("t1");

        // Three back-to-back bytes; the model enforces contiguous frames in order.
        bytes_buf[0] = 8'h55; bytes_buf[1] = 8'hAA; bytes_buf[2] = 8'h0F;
        push_burst(3);
        check("t2_count", 32'(fifo_count), 32'd2);
        wait_idle("t2");

        // Six pushes on an empty FIFO: one popped, four queued, sixth dropped.
        for (int i = 0; i < 6; i++) bytes_buf[i] = 8'h30 + 8'(i);
        push_burst(6);
        check("t3_overflow", 32'(overflow),   32'd1);
        check("t3_count",    32'(fifo_count), 32'd4);
        wait_idle("t3");
        check("t3_overflow_sticky", 32'(overflow), 32'd1);

        // Async reset in the middle of the 0xFF data bits.
        bytes_buf[0] = 8'hFF; bytes_buf[1] = 8'h12;
        push_burst(2);
        repeat (6) @(negedge clock);
        check("t4_pre_tx", 32'(tx), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("t4_rst_tx",       32'(tx),         32'd1);
        check("t4_rst_count",    32'(fifo_count), 32'd0);
        check("t4_rst_overflow", 32'(overflow),   32'd0);
        check("t4_rst_busy",     32'(busy),       32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        send_and_sample(8'h01, seq);
`ifdef UART_TX_PARITY_EN
        check("t4_frame_bits", 32'(seq), 32'h602);
`else
        check("t4_frame_bits", 32'(seq), 32'h202);
`endif
        wait_idle("t4");

        // Fill the FIFO, then push exactly on the edge where the first stop bit ends.
        for (int i = 0; i < 5; i++) bytes_buf[i] = 8'hA0 + 8'(i);
        push_burst(5);
        check("t5_full", 32'(fifo_count), 32'd4);
        e_stop = first_edge + 1 + FL * C;
        for (int k = 0; k < 200 && (cyc + 1 < e_stop); k++) @(negedge clock);
        check("t5_align", 32'(cyc + 1), 32'(e_stop));
        uart_in = {1'b1, 8'hC3};
        @(negedge clock);
        uart_in = 9'h000;
        check("t5_overflow", 32'(overflow),   32'd0);
        check("t5_count",    32'(fifo_count), 32'd4);
        check("t5_tx_start", 32'(tx),         32'd0);
        wait_idle("t5");
        check("t5_overflow_end", 32'(overflow), 32'd0);

`ifdef UART_TX_PARITY_EN
        send_and_sample(8'h07, seq);
        check("par_07", 32'(seq[9]), 32'd1);
        wait_idle("par07");
        send_and_sample(8'h03, seq);
        check("par_03", 32'(seq[9]), 32'd0);
        wait_idle("par03");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
